// File: rtl/uart_msg_scheduler.sv
// Arbitrates the single UART transmitter between coalesced sync markers and
// buffered note events, offering one byte at a time over a valid/ready handshake.
module uart_msg_scheduler #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sync_req,
  input  logic                          evt_push,
  input  logic [DATA_WIDTH-1:0]         evt_data,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          collision
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    sync_pending_r;
  logic                    overflow_r;
  logic                    collision_r;
  logic [DATA_WIDTH-1:0]   tx_data_r;
  logic                    tx_valid_r;

  logic                    full_s;
  logic                    evt_is_sync_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;

  assign full_s     = (count_r == DEPTH_C);
  assign fifo_full  = full_s;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign collision  = collision_r;
  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;

  // Push/pop decisions; a pop frees the slot a same-cycle push writes into.
  always_comb begin
    evt_is_sync_s = 1'b0;
    pop_s         = 1'b0;
    push_s        = 1'b0;
    drop_s        = 1'b0;
    evt_is_sync_s = (evt_data == SYNC_BYTE);
    if ((state_r == IDLE) && !sync_pending_r && (count_r != {CNT_W{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (evt_push && !evt_is_sync_s && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (evt_push && !evt_is_sync_s && full_s && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Event FIFO storage, pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= evt_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (evt_push && evt_is_sync_s) begin
        collision_r <= 1'b1;
      end
    end
  end

  // Transmit FSM with registered handshake outputs and the coalescing sync flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r        <= IDLE;
      tx_data_r      <= {DATA_WIDTH{1'b0}};
      tx_valid_r     <= 1'b0;
      sync_pending_r <= 1'b0;
    end else begin
      if (sync_req) begin
        sync_pending_r <= 1'b1;
      end else if ((state_r == IDLE) && sync_pending_r) begin
        sync_pending_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (sync_pending_r) begin
            tx_data_r  <= SYNC_BYTE;
            tx_valid_r <= 1'b1;
            state_r    <= SEND;
          end else if (pop_s) begin
            tx_data_r  <= mem_r[rd_ptr_r];
            tx_valid_r <= 1'b1;
            state_r    <= SEND;
          end else begin
            tx_valid_r <= 1'b0;
          end
        end
        SEND: begin
          if (tx_valid_r && tx_ready) begin
            tx_valid_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Scoreboard bench for uart_msg_scheduler: expected bytes are queued as
// stimulus is driven and matched against each completed handshake.
module tb_uart_msg_scheduler;

  logic       clk;
  logic       rstn;
  logic       sync_req;
  logic       evt_push;
  logic [7:0] evt_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       collision;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       hold_r   = 1'b0;
  logic [7:0] held_data_r = 8'h00;

  uart_msg_scheduler #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .SYNC_BYTE  (8'hFF)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sync_req   (sync_req),
    .evt_push   (evt_push),
    .evt_data   (evt_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .collision  (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
  endtask

  // Handshake monitor: every transfer must match the scoreboard head, and an
  // offered byte must stay valid and unchanged until it is accepted.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rstn) begin
      if (hold_r) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", {24'd0, tx_data}, {24'd0, held_data_r});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("byte_order", {24'd0, tx_data}, {24'd0, e});
        end
      end
      hold_r      <= tx_valid && !tx_ready;
      held_data_r <= tx_data;
    end else begin
      hold_r <= 1'b0;
    end
  end

  initial begin
    int sent;
    int cyc;
    rstn     = 1'b0;
    sync_req = 1'b0;
    evt_push = 1'b0;
    evt_data = 8'h00;
    tx_ready = 1'b0;

    // Reset
    repeat (3) tick();
    rstn = 1'b1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_collision", {31'd0, collision}, 32'd0);
    repeat (4) tick();
    check("idle_valid", {31'd0, tx_valid}, 32'd0);

    // Single event: offered two edges after the push
    evt_push = 1'b1;
    evt_data = 8'h3A;
    tx_ready = 1'b1;
    exp_q.push_back(8'h3A);
    tick();
    evt_push = 1'b0;
    check("single_count1", {29'd0, fifo_count}, 32'd1);
    check("single_notyet", {31'd0, tx_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, tx_valid}, 32'd1);
    check("single_data", {24'd0, tx_data}, 32'h3A);
    tick();
    check("single_drop", {31'd0, tx_valid}, 32'd0);
    check("single_count0", {29'd0, fifo_count}, 32'd0);
    wait_drain("single_drain", 10);

    // Priority and coalescing
    tx_ready = 1'b0;
    evt_push = 1'b1;
    evt_data = 8'h01;
    tick();
    evt_data = 8'h02;
    tick();
    evt_push = 1'b0;
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    tick();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    check("prio_head_valid", {31'd0, tx_valid}, 32'd1);
    check("prio_head_data", {24'd0, tx_data}, 32'h01);
    check("prio_count", {29'd0, fifo_count}, 32'd1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h02);
    tx_ready = 1'b1;
    wait_drain("prio_drain", 40);
    repeat (3) tick();
    check("prio_quiet", {31'd0, tx_valid}, 32'd0);

    // Overflow: one byte in SEND, four queued, sixth dropped
    tx_ready = 1'b0;
    evt_push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      evt_data = 8'h10 + 8'(i);
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    evt_push = 1'b0;
    check("ovf_count", {29'd0, fifo_count}, 32'd4);
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_send_data", {24'd0, tx_data}, 32'h10);
    tx_ready = 1'b1;
    wait_drain("ovf_drain", 60);
    check("ovf_empty", {29'd0, fifo_count}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Collision: the sync value is never queued
    evt_push = 1'b1;
    evt_data = 8'hFF;
    tick();
    evt_push = 1'b0;
    check("coll_flag", {31'd0, collision}, 32'd1);
    check("coll_count", {29'd0, fifo_count}, 32'd0);
    repeat (5) tick();
    check("coll_nosend", {31'd0, tx_valid}, 32'd0);

    // Reset mid-SEND abandons the offered byte
    tx_ready = 1'b0;
    evt_push = 1'b1;
    evt_data = 8'h55;
    tick();
    evt_push = 1'b0;
    tick();
    check("midrst_valid", {31'd0, tx_valid}, 32'd1);
    rstn = 1'b0;
    tick();
    check("midrst_drop", {31'd0, tx_valid}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_coll", {31'd0, collision}, 32'd0);
    rstn = 1'b1;
    repeat (3) tick();
    check("midrst_noresend", {31'd0, tx_valid}, 32'd0);

    // Stream 20 events through the wrapping pointers with tx_ready toggling
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 2000) begin
      tx_ready = ~tx_ready;
      if (fifo_count < 3'd3) begin
        evt_push = 1'b1;
        evt_data = 8'h20 + 8'(sent);
        exp_q.push_back(8'h20 + 8'(sent));
        sent++;
      end else begin
        evt_push = 1'b0;
      end
      tick();
      cyc++;
    end
    evt_push = 1'b0;
    check("stream_pushed", 32'(sent), 32'd20);
    tx_ready = 1'b1;
    wait_drain("stream_drain", 300);
    check("stream_no_ovf", {31'd0, overflow}, 32'd0);
    check("stream_empty", {29'd0, fifo_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
